// File: rtl/i2s_transmit_24.sv
// rtl/i2s_transmit_24.sv - I2S serial transmitter for stereo sample pairs, slaved to an external SCK/WS pair
//
// Ports:
//   clk_i          system clock; SCK is oversampled in this domain
//   rst_ni         asynchronous active-low reset
//   sck_i          I2S bit clock (generated in the clk_i domain)
//   ws_i           word select: 0 = left slot, 1 = right slot
//   left_i         left sample, two's complement, MSB sent first
//   right_i        right sample
//   valid_i        left_i/right_i carry a valid pair
//   ready_o        holding register empty; pair accepted on valid_i & ready_o
//   sd_o           registered serial data
//   frame_start_o  one-cycle pulse when a left slot begins
//   underrun_o     one-cycle pulse when a left slot begins with no pair held
module i2s_transmit_24 #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              frame_start_o,
    output logic              underrun_o
);

    // One extra bit so DATA_W == SLOT_W still compares correctly.
    localparam int CNT_W = $clog2(SLOT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);

    logic              sck_q;
    logic              ws_last;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    // Only the right word needs keeping: the left word goes straight from
    // the holding register into the shifter at the left slot start.
    logic [DATA_W-1:0] act_r;

    logic fall;
    logic ws_f;
    logic slot_start;
    logic left_start;
    logic accept;

    always_comb begin
        fall       = sck_q & ~sck_i;
        ws_f       = ws_i;
        slot_start = fall & (ws_f != ws_last);
        left_start = slot_start & ~ws_f;
        accept     = valid_i & ~hold_full;
    end

    assign ready_o = ~hold_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q         <= 1'b0;
            ws_last       <= 1'b1;
            bit_cnt       <= '0;
            shift         <= '0;
            hold_full     <= 1'b0;
            hold_l        <= '0;
            hold_r        <= '0;
            act_r         <= '0;
            sd_o          <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            sck_q         <= sck_i;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;

            // accept only fires while empty and the left start only clears
            // while full, so the two never fight over hold_full.
            if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= left_i;
                hold_r    <= right_i;
            end

            if (fall) begin
                ws_last <= ws_f;
                if (slot_start) begin
                    // The bit on the WS-change edge is the previous slot's
                    // last pad bit; the MSB follows one SCK later.
                    bit_cnt <= '0;
                    sd_o    <= 1'b0;
                    if (left_start) begin
                        frame_start_o <= 1'b1;
                        if (hold_full) begin
                            act_r     <= hold_r;
                            shift     <= hold_l;
                            hold_full <= 1'b0;
                        end else begin
                            act_r      <= '0;
                            shift      <= '0;
                            underrun_o <= 1'b1;
                        end
                    end else begin
                        shift <= act_r;
                    end
                end else begin
                    if (bit_cnt < DATA_CNT) begin
                        sd_o  <= shift[DATA_W-1];
                        shift <= {shift[DATA_W-2:0], 1'b0};
                    end else begin
                        sd_o <= 1'b0;
                    end
                    if (bit_cnt != CNT_MAX) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
